video_stream_gen: RTL

Video stream source for the image-processing pipeline. It produces frame-sync (`per_frame_vsync`), line-valid (`per_frame_href`) and 8-bit gray pixels (`per_img_Gray`) with programmable blanking. This is the same stream format consumed by the 3x3 matrix, filter and edge blocks.

- Pixels are fetched from an external line/frame store over a fixed-latency read port.
- Used as the stimulus/transmit end in simulation.
- Used as the replay source in hardware.

---
 rtl/video_stream_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/video_stream_gen.sv
// rtl/video_stream_gen.sv - vsync/href/gray video source with programmable blanking, fed from a 1-cycle-latency store
module video_stream_gen #(
  parameter logic [10:0] IMG_HDISP   = 11'd640,
  parameter logic [10:0] IMG_VDISP   = 11'd480,
  parameter logic [10:0] H_BACK      = 11'd40,
  parameter logic [10:0] H_FRONT     = 11'd120,
  parameter logic [10:0] VSYNC_LINES = 11'd2,
  parameter logic [10:0] V_BACK      = 11'd10,
  parameter logic [10:0] V_FRONT     = 11'd10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       src_rd_en,
  input  logic [7:0] src_data,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic [7:0] per_img_Gray,
  output logic       frame_done
);

  localparam logic [10:0] H_TOTAL = H_BACK + IMG_HDISP + H_FRONT;
  localparam logic [10:0] H_ACT_LAST = H_BACK + IMG_HDISP - 11'd1;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

  state_t      state, state_nxt;
  logic [10:0] h_cnt, v_cnt;
  logic        h_wrap, frame_exit;
  logic        href_d1, vsync_d1;

  assign h_wrap = (state != IDLE) && (h_cnt == H_TOTAL - 11'd1);

  // Every line-based exit happens on the last cycle of a line, so frames stay H_TOTAL aligned.
  always_comb begin
    state_nxt  = state;
    frame_exit = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = VSYNC;
      end
      VSYNC: begin
        if (h_wrap && (v_cnt == VSYNC_LINES - 11'd1))
          state_nxt = (V_BACK == 11'd0) ? ACTIVE : VBACK;
      end
      VBACK: begin
        if (h_wrap && (v_cnt == V_BACK - 11'd1)) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (h_wrap && (v_cnt == IMG_VDISP - 11'd1)) begin
          if (V_FRONT == 11'd0) frame_exit = 1'b1;
          else                  state_nxt  = VFRONT;
        end
      end
      VFRONT: begin
        if (h_wrap && (v_cnt == V_FRONT - 11'd1)) frame_exit = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (frame_exit) state_nxt = enable ? VSYNC : IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE || h_wrap) h_cnt <= 11'd0;
      else                         h_cnt <= h_cnt + 11'd1;
      if (state == IDLE || state_nxt != state) v_cnt <= 11'd0;
      else if (h_wrap)                         v_cnt <= v_cnt + 11'd1;
    end
  end

  assign src_rd_en  = (state == ACTIVE) && (h_cnt >= H_BACK) && (h_cnt <= H_ACT_LAST);
  assign frame_done = frame_exit;

  // Store data is valid the cycle after the strobe; it lands in the output register alongside href.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      href_d1         <= 1'b0;
      vsync_d1        <= 1'b0;
      per_frame_href  <= 1'b0;
      per_frame_vsync <= 1'b0;
      per_img_Gray    <= 8'd0;
    end else begin
      href_d1         <= src_rd_en;
      vsync_d1        <= (state == VSYNC);
      per_frame_href  <= href_d1;
      per_frame_vsync <= vsync_d1;
      per_img_Gray    <= href_d1 ? src_data : 8'd0;
    end
  end

endmodule
